// File: rtl/fht_in_loader.sv
// -----------------------------------------------------------------------------
// fht_in_loader
//
// Input loading stage in front of the FHT butterfly datapath. Serial signed
// samples arrive over a valid/ready handshake. Each sample is sign-extended to
// D_BIT and written into one of four data RAM banks at its bit-reversed frame
// position, so the butterfly stages can read the banks in natural order.
// After a full frame of N = 4 * 2^A_BIT samples the loader pulses oSTART and
// stays closed until the FHT core pulses iFHT_DONE.
//
// Ports:
//   iCLK       clock, all state updates on the rising edge
//   iRESET     synchronous active-high reset
//   iDATA      signed input sample (IN_BIT)
//   iVALID     sample present on iDATA
//   oREADY     loader accepts a sample this cycle (decoded from state)
//   iFHT_DONE  one-cycle pulse from FHT core: transform finished, banks free
//   oWR_DATA   bank write data, common to all banks (D_BIT)
//   oWR_ADDR   bank write address, common to all banks (A_BIT)
//   oWR_EN     one-hot bank write enable, bit k = bank k
//   oSTART     one-cycle pulse: frame loaded, FHT may begin
//   oBUSY      high from frame completion until iFHT_DONE is accepted
// -----------------------------------------------------------------------------
module fht_in_loader #(
    parameter int D_BIT  = 17,
    parameter int A_BIT  = 8,
    parameter int IN_BIT = 16
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [IN_BIT-1:0] iDATA,
    input  logic              iVALID,
    output logic              oREADY,
    input  logic              iFHT_DONE,
    output logic [D_BIT-1:0]  oWR_DATA,
    output logic [A_BIT-1:0]  oWR_ADDR,
    output logic [3:0]        oWR_EN,
    output logic              oSTART,
    output logic              oBUSY
);

    // Sample index width: two bank-select bits plus the bank address.
    localparam int C_BIT = A_BIT + 2;
    localparam logic [C_BIT-1:0] N_ONE  = {{(C_BIT-1){1'b0}}, 1'b1};
    localparam logic [C_BIT-1:0] N_LAST = {C_BIT{1'b1}};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [C_BIT-1:0]   n_q;
    logic [3:0]         wr_en_q;
    logic [A_BIT-1:0]   wr_addr_q;
    logic [D_BIT-1:0]   wr_data_q;
    logic               start_q;
    logic               busy_q;

    logic [C_BIT-1:0]   rev_s;
    logic [3:0]         wr_en_d;
    logic [A_BIT-1:0]   wr_addr_d;
    logic [D_BIT-1:0]   wr_data_d;
    logic               accept_s;

    // Mirror an index end-for-end over its full width.
    function automatic logic [C_BIT-1:0] bit_reverse(input logic [C_BIT-1:0] v);
        logic [C_BIT-1:0] r;
        r = {C_BIT{1'b0}};
        for (int i = 0; i < C_BIT; i++) begin
            r[i] = v[C_BIT-1-i];
        end
        return r;
    endfunction

    // Bit-reversed placement: low reversed bits pick the bank, the rest the address.
    always_comb begin
        rev_s     = bit_reverse(n_q);
        wr_en_d   = 4'b0001 << rev_s[1:0];
        wr_addr_d = rev_s[C_BIT-1:2];
        // Signed cast makes the size cast replicate the sign bit.
        wr_data_d = D_BIT'($signed(iDATA));
        accept_s  = iVALID && (state_q == ST_LOAD);
    end

    // Frame sequencing FSM with registered bank-write and handshake outputs.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q   <= ST_LOAD;
            n_q       <= {C_BIT{1'b0}};
            wr_en_q   <= 4'b0000;
            wr_addr_q <= {A_BIT{1'b0}};
            wr_data_q <= {D_BIT{1'b0}};
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // Write enable and start are single-cycle strobes.
            wr_en_q <= 4'b0000;
            start_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (accept_s) begin
                        wr_en_q   <= wr_en_d;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= wr_data_d;
                        if (n_q == N_LAST) begin
                            n_q     <= {C_BIT{1'b0}};
                            state_q <= ST_FLUSH;
                        end else begin
                            n_q <= n_q + N_ONE;
                        end
                    end else begin
                        n_q <= n_q;
                    end
                end
                // Last sample's write is on the bus during this state.
                ST_FLUSH: begin
                    state_q <= ST_START;
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (iFHT_DONE) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    n_q     <= {C_BIT{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oREADY   = (state_q == ST_LOAD);
    assign oWR_EN   = wr_en_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oSTART   = start_q;
    assign oBUSY    = busy_q;

endmodule

// File: tb/tb_fht_in_loader.sv
module tb_fht_in_loader;

    logic        iCLK;
    logic        iRESET;
    logic [15:0] iDATA;
    logic        iVALID;
    logic        oREADY;
    logic        iFHT_DONE;
    logic [16:0] oWR_DATA;
    logic [1:0]  oWR_ADDR;
    logic [3:0]  oWR_EN;
    logic        oSTART;
    logic        oBUSY;

    int n_tests = 0;
    int n_fail  = 0;
    int wcount  = 0;

    fht_in_loader #(.D_BIT(17), .A_BIT(2), .IN_BIT(16)) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iDATA     (iDATA),
        .iVALID    (iVALID),
        .oREADY    (oREADY),
        .iFHT_DONE (iFHT_DONE),
        .oWR_DATA  (oWR_DATA),
        .oWR_ADDR  (oWR_ADDR),
        .oWR_EN    (oWR_EN),
        .oSTART    (oSTART),
        .oBUSY     (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Frame-level model: accept count, whether the frame is closed, and
    // how many edges have passed since it closed.
    int          m_n;
    int          m_since;
    bit          m_closed;
    logic [3:0]  m_en;
    logic [1:0]  m_addr;
    logic [16:0] m_data;
    logic        m_start;
    logic        m_busy;
    logic        m_ready;
    int          r;
    int          v;

    initial begin
        forever begin
            @(posedge iCLK);
            if (iRESET) begin
                m_n = 0; m_closed = 0; m_since = 0;
                m_en = 4'b0000; m_addr = 2'd0; m_data = 17'd0;
                m_start = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
            end else begin
                m_en = 4'b0000;
                m_start = 1'b0;
                if (!m_closed) begin
                    if (iVALID) begin
                        r = 0;
                        for (int i = 0; i < 4; i++) r = r * 2 + ((m_n >> i) & 1);
                        m_en   = 4'b0001 << (r % 4);
                        m_addr = 2'(r / 4);
                        v = int'(iDATA);
                        if (v >= 32768) v = v - 65536;
                        m_data = 17'(v);
                        m_n++;
                        if (m_n == 16) begin
                            m_n = 0; m_closed = 1; m_since = 0;
                        end
                    end
                end else begin
                    m_since++;
                    if (m_since == 1) begin
                        m_start = 1'b1;
                        m_busy  = 1'b1;
                    end
                    if (m_since >= 3 && iFHT_DONE) begin
                        m_closed = 0;
                        m_busy   = 1'b0;
                    end
                end
                m_ready = !m_closed;
            end
            @(negedge iCLK);
            n_tests++;
            if (oWR_EN !== m_en) begin
                n_fail++; $display("FAIL model_wr_en got %b expected %b at %0t", oWR_EN, m_en, $time);
            end
            n_tests++;
            if (oWR_ADDR !== m_addr) begin
                n_fail++; $display("FAIL model_wr_addr got %0d expected %0d at %0t", oWR_ADDR, m_addr, $time);
            end
            n_tests++;
            if (oWR_DATA !== m_data) begin
                n_fail++; $display("FAIL model_wr_data got %h expected %h at %0t", oWR_DATA, m_data, $time);
            end
            n_tests++;
            if (oREADY !== m_ready) begin
                n_fail++; $display("FAIL model_ready got %b expected %b at %0t", oREADY, m_ready, $time);
            end
            n_tests++;
            if (oSTART !== m_start) begin
                n_fail++; $display("FAIL model_start got %b expected %b at %0t", oSTART, m_start, $time);
            end
            n_tests++;
            if (oBUSY !== m_busy) begin
                n_fail++; $display("FAIL model_busy got %b expected %b at %0t", oBUSY, m_busy, $time);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, return just after the rising edge.
    task automatic cyc(input logic vld, input logic [15:0] d, input logic done, input logic rst);
        @(negedge iCLK);
        iVALID = vld; iDATA = d; iFHT_DONE = done; iRESET = rst;
        @(posedge iCLK);
        #1;
        if (oWR_EN != 4'b0000) wcount++;
    endtask

    initial begin
        logic [15:0] d;
        iRESET = 1'b1; iVALID = 1'b0; iDATA = 16'h0000; iFHT_DONE = 1'b0;
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        check("rst_wr_en", 32'(oWR_EN), 32'h0);
        check("rst_addr", 32'(oWR_ADDR), 32'h0);
        check("rst_data", 32'(oWR_DATA), 32'h0);
        check("rst_start", 32'(oSTART), 32'h0);
        check("rst_busy", 32'(oBUSY), 32'h0);
        check("rst_ready", 32'(oREADY), 32'h1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);

        // Frame 1: continuous valid, stray done at n=7.
        for (int n = 0; n < 16; n++) begin
            d = (n == 0) ? 16'h8000 : (n == 1) ? 16'h7FFF : 16'(16'h0100 + n);
            cyc(1'b1, d, (n == 7), 1'b0);
            case (n)
                0: begin
                    check("n0_en", 32'(oWR_EN), 32'h1);
                    check("n0_addr", 32'(oWR_ADDR), 32'h0);
                    check("sext_neg", 32'(oWR_DATA), 32'h18000);
                end
                1: begin
                    check("n1_en", 32'(oWR_EN), 32'h1);
                    check("n1_addr", 32'(oWR_ADDR), 32'h2);
                    check("sext_pos", 32'(oWR_DATA), 32'h07FFF);
                end
                2: begin
                    check("n2_en", 32'(oWR_EN), 32'h1);
                    check("n2_addr", 32'(oWR_ADDR), 32'h1);
                end
                5: begin
                    check("n5_en", 32'(oWR_EN), 32'h4);
                    check("n5_addr", 32'(oWR_ADDR), 32'h2);
                end
                8: begin
                    check("stray_done_n8_en", 32'(oWR_EN), 32'h2);
                    check("stray_done_n8_addr", 32'(oWR_ADDR), 32'h0);
                end
                15: begin
                    check("n15_en", 32'(oWR_EN), 32'h8);
                    check("n15_addr", 32'(oWR_ADDR), 32'h3);
                    check("flush_ready", 32'(oREADY), 32'h0);
                    check("flush_start", 32'(oSTART), 32'h0);
                end
                default: ;
            endcase
        end
        cyc(1'b1, 16'hBAD1, 1'b0, 1'b0);
        check("start_pulse", 32'(oSTART), 32'h1);
        check("start_no_wr", 32'(oWR_EN), 32'h0);
        check("start_busy", 32'(oBUSY), 32'h1);
        for (int k = 2; k < 10; k++) begin
            cyc(1'b1, 16'(16'hBAD0 + k), (k == 2), 1'b0);
            check("wait_start_low", 32'(oSTART), 32'h0);
            check("wait_busy", 32'(oBUSY), 32'h1);
        end
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("done_busy", 32'(oBUSY), 32'h0);
        check("done_ready", 32'(oREADY), 32'h1);

        // Frame 2: valid toggling every cycle, garbage in the gaps.
        wcount = 0;
        for (int i = 0; i < 32; i++) begin
            cyc((i % 2 == 0), (i % 2 == 0) ? 16'(16'h2000 + i / 2) : 16'hDEAD, 1'b0, 1'b0);
            if (i == 0) begin
                check("gap_n0_en", 32'(oWR_EN), 32'h1);
                check("gap_n0_addr", 32'(oWR_ADDR), 32'h0);
                check("gap_n0_data", 32'(oWR_DATA), 32'h02000);
            end
            if (i == 1) check("gap_no_wr", 32'(oWR_EN), 32'h0);
        end
        check("gap_write_count", 32'(wcount), 32'd16);
        check("gap_start", 32'(oSTART), 32'h1);
        for (int k = 0; k < 5; k++) cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        check("wait_garbage_count", 32'(wcount), 32'd16);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        check("done2_busy", 32'(oBUSY), 32'h0);

        // Mid-frame reset after 9 accepts, with a sample offered in the reset cycle.
        for (int n = 0; n < 9; n++) cyc(1'b1, 16'(16'h3000 + n), 1'b0, 1'b0);
        cyc(1'b1, 16'h3333, 1'b0, 1'b1);
        check("mid_rst_en", 32'(oWR_EN), 32'h0);
        check("mid_rst_start", 32'(oSTART), 32'h0);
        check("mid_rst_ready", 32'(oREADY), 32'h1);
        for (int k = 0; k < 5; k++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int n = 0; n < 16; n++) begin
            cyc(1'b1, 16'(16'h4000 + n), 1'b0, 1'b0);
            if (n == 0) begin
                check("fresh_n0_en", 32'(oWR_EN), 32'h1);
                check("fresh_n0_addr", 32'(oWR_ADDR), 32'h0);
            end
            if (n == 1) check("fresh_n1_addr", 32'(oWR_ADDR), 32'h2);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        check("fresh_start", 32'(oSTART), 32'h1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset while waiting for the core.
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        check("wait_rst_busy", 32'(oBUSY), 32'h0);
        check("wait_rst_ready", 32'(oREADY), 32'h1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fht_in_loader.md
Name: fht_in_loader

Overview:
Input loading stage directly upstream of the FHT butterfly datapath. It accepts a serial stream of signed samples over a valid/ready handshake. Each sample is sign-extended to D_BIT and written into the four data RAM banks (bank 0..3) at bit-reversed positions, so the butterfly stages read the banks in natural order. After a full frame it pulses a start strobe to the FHT core, then stays closed until the core reports completion.

Parameters:
D_BIT, 17, bank data width (matches butterfly datapath width)
A_BIT, 8, bank address width; frame size N = 4 * 2^A_BIT points
IN_BIT, 16, input sample width; must be <= D_BIT

Ports:
iCLK  in  1  clock
iRESET  in  1  reset
iDATA  in  IN_BIT  signed input sample
iVALID  in  1  sample present on iDATA
oREADY  out  1  loader accepts a sample this cycle
iFHT_DONE  in  1  one-cycle pulse from FHT core: transform finished, banks free
oWR_DATA  out  D_BIT  write data, common to all banks
oWR_ADDR  out  A_BIT  write address, common to all banks
oWR_EN  out  4  one-hot bank write enable, bit k = bank k
oSTART  out  1  one-cycle pulse: frame loaded, FHT may begin
oBUSY  out  1  high from frame completion until iFHT_DONE accepted

Behaviour:
- Reset: one clock, iRESET synchronous, active-high; all state updates on rising edge of iCLK.
- Reset values: state LOAD, sample counter n = 0, oWR_EN = 0, oWR_DATA = 0, oWR_ADDR = 0, oSTART = 0, oBUSY = 0. oREADY is decoded from state, so it reads 1 from the first edge after reset.
- Accept: a sample is accepted on any edge where iVALID && oREADY. iDATA is ignored when oREADY = 0.
- Address mapping: n is the (A_BIT+2)-bit index of the sample in the frame, 0..N-1. r = bit-reverse of n over A_BIT+2 bits. Bank = r[1:0]; address = r[A_BIT+1:2].
- Write timing: registered, latency 1. The accept at edge t drives oWR_EN = one-hot(bank), oWR_ADDR and oWR_DATA during cycle t+1.
  - oWR_EN = 0 in every cycle that does not follow an accept.
  - oWR_DATA/oWR_ADDR hold their last value when not writing.
- Data: oWR_DATA = iDATA sign-extended from IN_BIT to D_BIT. No scaling, no saturation.
- States:
  - LOAD: oREADY = 1. Each accept increments n. The accept with n = N-1 sets n to 0 and moves to FLUSH.
  - FLUSH (1 cycle): oREADY = 0. The last sample's write occurs in this cycle. Moves to START.
  - START (1 cycle): oSTART = 1, oBUSY = 1, oREADY = 0. Moves to WAIT.
  - WAIT: oBUSY = 1, oREADY = 0. On iFHT_DONE = 1 moves to LOAD, with oBUSY = 0 and oREADY = 1 from the next cycle.
- oSTART occurs exactly 2 cycles after the last accept and never overlaps any oWR_EN.
- iFHT_DONE is ignored in LOAD, FLUSH and START; it is not latched.
- iVALID gaps are allowed anywhere in LOAD. The counter holds and no write occurs.
- Reset mid-frame: partial frame abandoned, n = 0, no oSTART. A pending write in the reset cycle is suppressed (oWR_EN = 0 after the edge).
- Reset in WAIT: returns to LOAD; oBUSY = 0.
- Exactly N writes per frame, with each (bank, addr) pair written exactly once.

Test Plan:
- Mapping (A_BIT=2, N=16, IN_BIT=16, D_BIT=17): stream n = 0..15 with iVALID continuous. Sample n=1 -> oWR_EN=0001, addr 2. n=2 -> 0001, addr 1. n=5 -> 0100, addr 2. n=15 -> 1000, addr 3. Each write occurs 1 cycle after its accept.
- Sign extension: iDATA = 16'h8000 -> oWR_DATA = 17'h18000. iDATA = 16'h7FFF -> 17'h07FFF.
- Frame end: with continuous iVALID, the last accept at cycle t gives oREADY = 0 from t+1, the last write at t+1, and oSTART = 1 only at t+2. oBUSY stays 1 until iFHT_DONE is pulsed at t+10; oREADY = 1 at t+11, and the next frame's sample 0 goes to bank 0 addr 0.
- Backpressure and gaps: toggle iVALID 1/0 every cycle -> 16 writes over 32 cycles, identical bank/addr sequence. iDATA driven with garbage while iVALID = 0 or during WAIT -> never written.
- Stray done: pulse iFHT_DONE during LOAD at n = 7 -> no state change, n continues to 8.
- Mid-frame reset: assert iRESET after 9 accepts -> no oSTART. After release, 16 fresh samples produce a full frame starting at n = 0.
